// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the command master's state type.
package ahb_pkg;

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'b00,
      HTRANS_BUSY   = 2'b01,
      HTRANS_NONSEQ = 2'b10,
      HTRANS_SEQ    = 2'b11
   } htrans_e;

   localparam logic [2:0] HSIZE_WORD      = 3'b010;
   localparam logic [2:0] HBURST_SINGLE   = 3'b000;
   localparam logic [3:0] HPROT_DATA_PRIV = 4'b0011;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_ADDR = 2'b01,
      ST_DATA = 2'b10,
      ST_RESP = 2'b11
   } cmd_state_e;

endpackage

// File: rtl/ahb_cmd_master.sv
// Single-transfer AHB-Lite master: turns one command into one word transfer
// and returns a response, with a data-phase wait-state timeout.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | ready for a command
// ST_ADDR | address phase driven (NONSEQ), waiting for HREADY
// ST_DATA | data phase, counting wait states toward the timeout
// ST_RESP | response presented until rsp_ready
module ahb_cmd_master
   import ahb_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 256
) (
   input  logic        HCLK,
   input  logic        HRESETn,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [31:0] cmd_addr,
   input  logic        cmd_write,
   input  logic [31:0] cmd_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        rsp_timeout,
   output logic [31:0] HADDR,
   output logic [1:0]  HTRANS,
   output logic        HWRITE,
   output logic [2:0]  HSIZE,
   output logic [2:0]  HBURST,
   output logic [3:0]  HPROT,
   output logic        HMASTLOCK,
   output logic [31:0] HWDATA,
   input  logic [31:0] HRDATA,
   input  logic        HREADY,
   input  logic        HRESP
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   cmd_state_e       state, state_nxt;
   logic [31:0]      addr_q;
   logic             write_q;
   logic [31:0]      wdata_q;
   logic [31:0]      hwdata_q;
   logic [CNT_W-1:0] wait_cnt;
   logic [31:0]      rdata_q;
   logic             err_q;
   logic             timeout_q;

   logic accept;
   logic misaligned;
   logic data_done;
   logic timeout_hit;

   // cmd_ready is gated by reset so it stays low while HRESETn is asserted
   assign cmd_ready   = (state == ST_IDLE) && HRESETn;
   assign accept      = cmd_valid && cmd_ready;
   assign misaligned  = (cmd_addr[1:0] != 2'b00);
   assign data_done   = (state == ST_DATA) && HREADY;
   assign timeout_hit = (state == ST_DATA) && !HREADY && (wait_cnt == CNT_LAST);

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (accept) begin
               state_nxt = misaligned ? ST_RESP : ST_ADDR;
            end
         end
         ST_ADDR: begin
            if (HREADY) begin
               state_nxt = ST_DATA;
            end
         end
         ST_DATA: begin
            if (data_done || timeout_hit) begin
               state_nxt = ST_RESP;
            end
         end
         ST_RESP: begin
            if (rsp_ready) begin
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         addr_q    <= '0;
         write_q   <= 1'b0;
         wdata_q   <= '0;
         hwdata_q  <= '0;
         wait_cnt  <= '0;
         rdata_q   <= '0;
         err_q     <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         if (accept) begin
            addr_q  <= cmd_addr;
            write_q <= cmd_write;
            wdata_q <= cmd_wdata;
         end

         if ((state == ST_ADDR) && HREADY) begin
            hwdata_q <= wdata_q;
            wait_cnt <= '0;
         end else if ((state == ST_DATA) && !HREADY) begin
            wait_cnt <= wait_cnt + 1'b1;
         end

         if (accept && misaligned) begin
            rdata_q   <= '0;
            err_q     <= 1'b1;
            timeout_q <= 1'b0;
         end else if (data_done) begin
            rdata_q   <= (!write_q && !HRESP) ? HRDATA : 32'h0;
            err_q     <= HRESP;
            timeout_q <= 1'b0;
         end else if (timeout_hit) begin
            rdata_q   <= '0;
            err_q     <= 1'b1;
            timeout_q <= 1'b1;
         end
      end
   end

   // address and direction stay on the bus through the data phase so the
   // slave can still decode read data from HADDR
   assign HADDR       = addr_q;
   assign HWRITE      = write_q;
   assign HTRANS      = (state == ST_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
   assign HSIZE       = HSIZE_WORD;
   assign HBURST      = HBURST_SINGLE;
   assign HPROT       = HPROT_DATA_PRIV;
   assign HMASTLOCK   = 1'b0;
   assign HWDATA      = hwdata_q;

   assign rsp_valid   = (state == ST_RESP);
   assign rsp_rdata   = rdata_q;
   assign rsp_err     = err_q;
   assign rsp_timeout = timeout_q;

endmodule

// File: tb/tb_ahb_cmd_master.sv
// Randomised bench for ahb_cmd_master: timer/RAM slave model, a transaction-level
// expectation queue and one per-cycle compare process.
module tb_ahb_cmd_master;

   localparam int TO = 8;
   localparam logic [31:0] TIMER_ID = 32'h5449_4D52;

   logic        HCLK;
   logic        HRESETn;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [31:0] cmd_addr;
   logic        cmd_write;
   logic [31:0] cmd_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        rsp_timeout;
   logic [31:0] HADDR;
   logic [1:0]  HTRANS;
   logic        HWRITE;
   logic [2:0]  HSIZE;
   logic [2:0]  HBURST;
   logic [3:0]  HPROT;
   logic        HMASTLOCK;
   logic [31:0] HWDATA;
   logic [31:0] HRDATA;
   logic        HREADY;
   logic        HRESP;

   ahb_cmd_master #(.TIMEOUT_CYCLES(TO)) dut (
      .HCLK(HCLK), .HRESETn(HRESETn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
      .cmd_write(cmd_write), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
      .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
      .HBURST(HBURST), .HPROT(HPROT), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA),
      .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
   );

   initial HCLK = 1'b0;
   always #5 HCLK = ~HCLK;

   int n_cmp  = 0;
   int n_fail = 0;
   int cyc    = 0;
   always @(posedge HCLK) cyc <= cyc + 1;

   function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endfunction

   // ---------------- slave: timer at 0x4000_00xx, 16-word RAM elsewhere ----------------
   int          cfg_wait;
   bit          cfg_err;
   bit          cfg_stuck;
   bit          s_in_data;
   logic [31:0] s_addr;
   bit          s_write;
   int          s_wait;
   bit          s_err;
   bit          s_stuck;
   bit          timer_en;
   logic [31:0] timer_cnt;
   logic [31:0] slv_ram [16];

   always @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         s_in_data <= 1'b0;
         s_addr    <= '0;
         s_write   <= 1'b0;
         s_wait    <= 0;
         s_err     <= 1'b0;
         s_stuck   <= 1'b0;
         timer_en  <= 1'b0;
         timer_cnt <= '0;
         for (int i = 0; i < 16; i++) slv_ram[i] <= '0;
      end else begin
         if (timer_en) timer_cnt <= timer_cnt + 1;
         if (s_in_data) begin
            if (s_stuck) begin
               if (rsp_valid) s_in_data <= 1'b0;
            end else if (s_wait != 0) begin
               s_wait <= s_wait - 1;
            end else begin
               s_in_data <= 1'b0;
               if (s_write && !s_err) begin
                  if (s_addr[31:28] == 4'h4) begin
                     if (s_addr[3:2] == 2'd2) begin
                        timer_en  <= HWDATA[0];
                        timer_cnt <= '0;
                     end
                  end else begin
                     slv_ram[s_addr[5:2]] <= HWDATA;
                  end
               end
            end
         end else if (HTRANS == 2'b10 && HREADY) begin
            s_in_data <= 1'b1;
            s_addr    <= HADDR;
            s_write   <= HWRITE;
            s_wait    <= cfg_wait;
            s_err     <= cfg_err;
            s_stuck   <= cfg_stuck;
         end
      end
   end

   always_comb begin
      HREADY = !(s_in_data && (s_stuck || s_wait != 0));
      HRESP  = s_in_data && s_err && (s_wait <= 1);
      HRDATA = '0;
      if (s_in_data) begin
         if (s_addr[31:28] == 4'h4) begin
            case (s_addr[3:2])
               2'd0:    HRDATA = timer_cnt;
               2'd2:    HRDATA = {31'b0, timer_en};
               2'd3:    HRDATA = TIMER_ID;
               default: HRDATA = '0;
            endcase
         end else begin
            HRDATA = slv_ram[s_addr[5:2]];
         end
      end
   end

   // ---------------- transaction-level expectation ----------------
   typedef struct {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic        write;
      logic        aligned;
      logic        err;
      logic        tout;
      logic        rd_dc;
      logic        seen;
      int          acc;
      int          rsp_cyc;
   } exp_t;

   exp_t        q[$];
   logic [31:0] mdl_ram [16];
   logic        mdl_ctrl;
   logic [31:0] last_hw;
   bit          chk_en;
   int          rdy_pct;

   int          last_lat;
   logic [31:0] last_rdata;
   logic        last_err;
   logic        last_to;

   // The master is busy from acceptance until the response is taken; the bus
   // shows NONSEQ only in the cycle after acceptance, then a data phase lasting
   // (slave waits + 1) cycles, or TO cycles against a stuck slave.
   task automatic predict(inout exp_t e, input int w, input bit er, input bit st);
      e.rdata = '0; e.err = 1'b0; e.tout = 1'b0; e.rd_dc = 1'b0; e.seen = 1'b0;
      e.aligned = (e.addr[1:0] == 2'b00);
      if (!e.aligned) begin
         e.rsp_cyc = e.acc;
         e.err = 1'b1;
      end else if (st) begin
         e.rsp_cyc = e.acc + 1 + TO;
         e.err = 1'b1;
         e.tout = 1'b1;
      end else begin
         e.rsp_cyc = e.acc + 2 + w;
         e.err = er;
         if (!er) begin
            if (e.write) begin
               if (e.addr == 32'h4000_0008) mdl_ctrl = e.wdata[0];
               else if (e.addr[31:28] != 4'h4) mdl_ram[e.addr[5:2]] = e.wdata;
            end else if (e.addr == 32'h4000_000C) begin
               e.rdata = TIMER_ID;
            end else if (e.addr == 32'h4000_0008) begin
               e.rdata = {31'b0, mdl_ctrl};
            end else if (e.addr == 32'h4000_0000) begin
               e.rd_dc = 1'b1;
            end else if (e.addr[31:28] != 4'h4) begin
               e.rdata = mdl_ram[e.addr[5:2]];
            end
         end
      end
   endtask

   task automatic send(input logic [31:0] a, input logic wr, input logic [31:0] wd,
                       input int w, input bit er, input bit st);
      exp_t e;
      bit   ok;
      int   c_acc;
      cfg_wait = w; cfg_err = er; cfg_stuck = st;
      @(negedge HCLK); #1;
      cmd_valid = 1'b1; cmd_addr = a; cmd_write = wr; cmd_wdata = wd;
      ok = 1'b0;
      c_acc = 0;
      for (int i = 0; i < 50 && !ok; i++) begin
         if (cmd_ready) begin
            c_acc = cyc + 1;
            @(posedge HCLK); #1;
            ok = 1'b1;
         end else begin
            @(negedge HCLK); #1;
         end
      end
      cmd_valid = 1'b0;
      cmd_addr = $urandom; cmd_write = 1'($urandom); cmd_wdata = $urandom;
      chk("cmd_accept", 32'(ok), 32'd1);
      if (ok) begin
         e.addr = a; e.wdata = wd; e.write = wr; e.acc = c_acc;
         predict(e, w, er, st);
         q.push_back(e);
      end
   endtask

   task automatic issue(input logic [31:0] a, input logic wr, input logic [31:0] wd,
                        input int w, input bit er, input bit st);
      send(a, wr, wd, w, er, st);
      for (int i = 0; i < 200 && q.size() != 0; i++) @(negedge HCLK);
      chk("rsp_drain", 32'(q.size()), 32'd0);
      q.delete();
   endtask

   // ---------------- per-cycle compare ----------------
   exp_t t;
   bit   has, exp_rv, in_addr, in_data, hw_new;

   initial begin
      forever begin
         @(negedge HCLK);
         if (chk_en && HRESETn) begin
            has = (q.size() != 0);
            if (has) t = q[0];
            exp_rv  = has && (cyc >= t.rsp_cyc);
            in_addr = has && t.aligned && (cyc == t.acc);
            in_data = has && t.aligned && (cyc > t.acc) && (cyc < t.rsp_cyc);
            hw_new  = has && t.aligned && (cyc > t.acc);
            chk("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
            chk("cmd_ready", 32'(cmd_ready), 32'(!has));
            chk("ready_and_valid", 32'(rsp_valid & cmd_ready), 32'd0);
            chk("htrans", 32'(HTRANS), in_addr ? 32'd2 : 32'd0);
            chk("hmastlock", 32'(HMASTLOCK), 32'd0);
            chk("hwdata", HWDATA, hw_new ? t.wdata : last_hw);
            if (in_addr || in_data) begin
               chk("haddr", HADDR, t.addr);
               chk("hwrite", 32'(HWRITE), 32'(t.write));
            end
            if (in_addr) begin
               chk("hsize", 32'(HSIZE), 32'd2);
               chk("hburst", 32'(HBURST), 32'd0);
               chk("hprot", 32'(HPROT), 32'd3);
            end
            if (rsp_valid && exp_rv) begin
               if (!q[0].seen) begin
                  q[0].seen  = 1'b1;
                  last_lat   = cyc - t.acc;
                  last_rdata = rsp_rdata;
                  last_err   = rsp_err;
                  last_to    = rsp_timeout;
               end
               chk("rsp_err", 32'(rsp_err), 32'(t.err));
               chk("rsp_timeout", 32'(rsp_timeout), 32'(t.tout));
               if (!t.rd_dc) chk("rsp_rdata", rsp_rdata, t.rdata);
            end
            rsp_ready = ($urandom_range(0, 99) < rdy_pct);
            if (rsp_valid && rsp_ready && exp_rv) begin
               if (t.aligned) last_hw = t.wdata;
               void'(q.pop_front());
            end
         end
      end
   end

   task automatic check_reset_vals(input string tag);
      chk({tag, "_haddr"}, HADDR, 32'h0);
      chk({tag, "_htrans"}, 32'(HTRANS), 32'd0);
      chk({tag, "_hwrite"}, 32'(HWRITE), 32'd0);
      chk({tag, "_hwdata"}, HWDATA, 32'h0);
      chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
      chk({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
      chk({tag, "_rsp_timeout"}, 32'(rsp_timeout), 32'd0);
      chk({tag, "_rsp_rdata"}, rsp_rdata, 32'h0);
      chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd0);
   endtask

   task automatic model_reset();
      q.delete();
      last_hw = '0;
      mdl_ctrl = 1'b0;
      for (int i = 0; i < 16; i++) mdl_ram[i] = '0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] a;
      logic        wr;
      int          w, r;
      bit          er, st;

      HRESETn = 1'b0; chk_en = 1'b0; rdy_pct = 100;
      cmd_valid = 1'b0; cmd_addr = '0; cmd_write = 1'b0; cmd_wdata = '0;
      rsp_ready = 1'b0; cfg_wait = 0; cfg_err = 1'b0; cfg_stuck = 1'b0;
      last_lat = -1; last_rdata = '0; last_err = 1'b0; last_to = 1'b0;
      model_reset();

      repeat (2) @(negedge HCLK);
      #1 check_reset_vals("por");
      #1 HRESETn = 1'b1;
      #1 chk("cmd_ready_after_reset", 32'(cmd_ready), 32'd1);
      chk_en = 1'b1;

      // zero-wait ID read: response visible two edges after the accept cycle
      issue(32'h4000_000C, 1'b0, 32'h1234_5678, 0, 1'b0, 1'b0);
      chk("id_latency", 32'(last_lat), 32'd2);
      chk("id_rdata", last_rdata, TIMER_ID);
      chk("id_err", 32'(last_err), 32'd0);

      issue(32'h4000_0008, 1'b1, 32'h0000_0001, 0, 1'b0, 1'b0);
      issue(32'h4000_0000, 1'b0, 32'hCAFE_0000, 0, 1'b0, 1'b0);
      chk("timer_count_small", 32'(last_rdata < 32'd10), 32'd1);
      chk("timer_err", 32'(last_err), 32'd0);

      issue(32'h4000_000C, 1'b0, 32'h0BAD_F00D, 3, 1'b0, 1'b0);
      chk("wait3_latency", 32'(last_lat), 32'd5);
      chk("wait3_rdata", last_rdata, TIMER_ID);

      issue(32'h2000_0004, 1'b1, 32'hA5A5_0001, 0, 1'b0, 1'b0);
      issue(32'h2000_0004, 1'b0, 32'h0, 1, 1'b1, 1'b0);
      chk("error_latency", 32'(last_lat), 32'd3);
      chk("error_err", 32'(last_err), 32'd1);
      chk("error_rdata", last_rdata, 32'h0);
      issue(32'h2000_0004, 1'b0, 32'h0, 0, 1'b0, 1'b0);
      chk("ram_readback", last_rdata, 32'hA5A5_0001);

      issue(32'h2000_0008, 1'b0, 32'h7777_7777, 0, 1'b0, 1'b1);
      chk("timeout_latency", 32'(last_lat), 32'd9);
      chk("timeout_err", 32'(last_err), 32'd1);
      chk("timeout_flag", 32'(last_to), 32'd1);

      issue(32'h4000_0002, 1'b0, 32'h0, 0, 1'b0, 1'b0);
      chk("misaligned_latency", 32'(last_lat), 32'd0);
      chk("misaligned_err", 32'(last_err), 32'd1);
      chk("misaligned_timeout", 32'(last_to), 32'd0);
      chk("misaligned_rdata", last_rdata, 32'h0);

      // reset pulse during a stalled data phase
      send(32'h2000_0010, 1'b1, 32'h5555_AAAA, 0, 1'b0, 1'b1);
      repeat (3) @(negedge HCLK);
      #2 chk_en = 1'b0;
      HRESETn = 1'b0;
      #1 check_reset_vals("mid_reset");
      model_reset();
      cfg_stuck = 1'b0;
      repeat (2) @(negedge HCLK);
      #2 HRESETn = 1'b1;
      #1 chk("cmd_ready_after_midreset", 32'(cmd_ready), 32'd1);
      chk_en = 1'b1;
      repeat (10) @(negedge HCLK);

      rdy_pct = 50;
      for (int n = 0; n < 60; n++) begin
         r  = $urandom_range(0, 99);
         a  = 32'h2000_0000 | (32'($urandom_range(0, 15)) << 2);
         wr = 1'($urandom_range(0, 1));
         if (r < 10) a[1:0] = 2'($urandom_range(1, 3));
         else if (r < 16) begin
            a  = 32'h4000_000C;
            wr = 1'b0;
         end
         st = ($urandom_range(0, 99) < 8);
         er = !st && ($urandom_range(0, 99) < 18);
         w  = $urandom_range(0, 3);
         if (er && w == 0) w = 1;
         repeat ($urandom_range(0, 2)) @(negedge HCLK);
         issue(a, wr, $urandom, w, er, st);
      end

      repeat (4) @(negedge HCLK);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/ahb_cmd_master.md
AHB_CMD_MASTER -- requirements
Module: ahb_cmd_master

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 256: maximum data-phase wait-state cycles before abort.
REQ-002 SHALL have ports (clock and reset first):
- HCLK  in  1  system clock
- HRESETn  in  1  asynchronous active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when high with cmd_valid
- cmd_addr  in  32  byte address
- cmd_write  in  1  1=write, 0=read
- cmd_wdata  in  32  write data
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed when high with rsp_valid
- rsp_rdata  out  32  read data (0 for writes and errors)
- rsp_err  out  1  transfer failed
- rsp_timeout  out  1  failure caused by timeout
- HADDR  out  32
- HTRANS  out  2
- HWRITE  out  1
- HSIZE  out  3
- HBURST  out  3
- HPROT  out  4
- HMASTLOCK  out  1
- HWDATA  out  32
- HRDATA  in  32
- HREADY  in  1
- HRESP  in  1
REQ-003 SHALL use one clock, HCLK; reset HRESETn is asynchronous and active-low.

Function
REQ-004 SHALL implement FSM states IDLE, ADDR, DATA, RESP; one transfer outstanding at most.
REQ-005 cmd_ready SHALL be 1 only in IDLE; on cmd_valid&cmd_ready, latch addr/write/wdata.
REQ-006 Accepted cmd with cmd_addr[1:0]!=0 SHALL skip the bus, go to RESP with rsp_err=1, rsp_timeout=0, rsp_rdata=0.
REQ-007 Aligned cmd SHALL go to ADDR next cycle.
REQ-008 ADDR: HTRANS=NONSEQ (2'b10), HADDR/HWRITE from latch, HSIZE=3'b010, HBURST=SINGLE, HPROT=4'b0011, HMASTLOCK=0; advance to DATA on the first edge with HREADY=1, else hold all signals.
REQ-009 DATA: HTRANS=IDLE; HADDR and HWRITE SHALL keep the transfer's values (slaves may decode read data from HADDR); HWDATA=latched wdata.
REQ-010 DATA with HREADY=1: capture HRDATA (reads only), set rsp_err=HRESP, go to RESP.
REQ-011 HRESP=1 with HREADY=0 (first error cycle) SHALL keep HTRANS=IDLE and wait for HREADY=1.
REQ-012 Wait-state counter SHALL clear on entering DATA and count DATA cycles with HREADY=0. On reaching TIMEOUT_CYCLES: go to RESP with rsp_err=1, rsp_timeout=1, rsp_rdata=0.
REQ-013 RESP: rsp_valid=1, outputs stable until rsp_ready=1, then IDLE.
REQ-014 Latency with a zero-wait slave: cmd accepted at edge N, ADDR in cycle N+1, DATA in N+2, rsp_valid in N+3.
REQ-015 Outside ADDR: HTRANS=IDLE; HWDATA SHALL hold its last value.
REQ-016 rsp_valid and cmd_ready SHALL never both be 1.

Reset
REQ-017 Reset values: state IDLE; HADDR=0, HTRANS=2'b00, HWRITE=0, HWDATA=0, rsp_valid=0, rsp_err=0, rsp_timeout=0, rsp_rdata=0, counter=0.
REQ-018 During reset cmd_ready SHALL be 0; it is 1 from the first cycle after deassertion.
REQ-019 Reset mid-transfer SHALL abort immediately and discard any pending response.

Structure
REQ-020 Package ahb_pkg SHALL hold HTRANS codes (IDLE/BUSY/NONSEQ/SEQ), HSIZE_WORD, HBURST_SINGLE, HPROT_DATA_PRIV, and the FSM state enum.
REQ-021 SHALL be a single module with no sub-modules; the timeout counter is inline, width $clog2(TIMEOUT_CYCLES+1).

Verification
REQ-022 Read 0x4000_000C from the timer slave (zero-wait) -> rsp_valid at N+3, rsp_rdata=0x5449_4D52, rsp_err=0.
REQ-023 Write 0x4000_0008 data 0x1, then read 0x4000_0000 -> returned count is small (< 10), rsp_err=0.
REQ-024 Slave inserts 3 wait states -> ADDR/HWDATA held, rsp_valid 3 cycles later than REQ-014, data correct.
REQ-025 Slave two-cycle ERROR (HRESP=1 with HREADY=0, then HREADY=1) -> rsp_err=1, HTRANS=IDLE throughout.
REQ-026 HREADY stuck low, TIMEOUT_CYCLES=8 -> rsp_err=1, rsp_timeout=1 after 8 DATA cycles.
REQ-027 cmd_addr=0x4000_0002 -> no NONSEQ on bus, rsp_err=1; HRESETn pulsed in DATA -> all outputs at reset values, no rsp_valid.
